// File: rtl/dec_timer_if.sv
// dec_timer_if: control and status bundle for the loadable down-counter timer.
interface dec_timer_if #(parameter int WIDTH = 8);
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             reload;
    logic             en;
    logic             stop;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             tc;
    modport master (output load, load_val, reload, en, stop, input count, busy, tc);
    modport slave (input load, load_val, reload, en, stop, output count, busy, tc);
endinterface

// File: rtl/dec_timer.sv
// dec_timer: loadable down-counter with terminal-count pulse, one-shot or periodic reload.
module dec_timer #(
    parameter int WIDTH = 8,
    parameter int STEP  = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    dec_timer_if.slave   b
);
    typedef enum logic {IDLE, RUN} state_t;
    localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);
    state_t           state, state_n;
    logic [WIDTH-1:0] count, count_n, rld, rld_n;
    logic             tc, tc_n;
    always_comb begin
        state_n = state;
        count_n = count;
        rld_n   = rld;
        tc_n    = 1'b0;
        if (b.load) begin
            count_n = b.load_val;
            rld_n   = b.load_val;
            state_n = (b.load_val != '0) ? RUN : IDLE;
        end else if (b.stop) begin
            state_n = IDLE;
        end else if (state == RUN && b.en) begin
            // Terminal when the next subtraction would reach or pass zero.
            tc_n    = (count <= STEP_W);
            count_n = !tc_n ? count - STEP_W : (b.reload ? rld : '0);
            state_n = (!tc_n || b.reload) ? RUN : IDLE;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            count <= '0;
            rld   <= '0;
            tc    <= 1'b0;
        end else begin
            state <= state_n;
            count <= count_n;
            rld   <= rld_n;
            tc    <= tc_n;
        end
    end
    assign b.count = count;
    assign b.busy  = (state == RUN);
    assign b.tc    = tc;
endmodule
